// File: rtl/apb_gpio_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// apb_gpio_pkg
// Shared definitions for the APB GPIO slave: bus widths, register byte
// offsets and their word indices, the APB transfer FSM state encoding and
// the wait-state ceiling.
// ---------------------------------------------------------------------------
package apb_gpio_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 32;

  // Register byte offsets
  localparam logic [7:0] REG_DATA_OUT = 8'h00;
  localparam logic [7:0] REG_DATA_IN  = 8'h04;
  localparam logic [7:0] REG_DIR      = 8'h08;
  localparam logic [7:0] REG_INT_EN   = 8'h0C;
  localparam logic [7:0] REG_INT_EDGE = 8'h10;
  localparam logic [7:0] REG_INT_STAT = 8'h14;

  // Word indices (byte offset with the two byte-lane bits dropped)
  localparam logic [5:0] IDX_DATA_OUT = REG_DATA_OUT[7:2];
  localparam logic [5:0] IDX_DATA_IN  = REG_DATA_IN[7:2];
  localparam logic [5:0] IDX_DIR      = REG_DIR[7:2];
  localparam logic [5:0] IDX_INT_EN   = REG_INT_EN[7:2];
  localparam logic [5:0] IDX_INT_EDGE = REG_INT_EDGE[7:2];
  localparam logic [5:0] IDX_INT_STAT = REG_INT_STAT[7:2];

  localparam int MAX_WAIT = 3;
  localparam int CNT_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_gpio_slave_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// apb_gpio_slave_if
// APB3 signal bundle between the bridge (master) and the GPIO slave.
//   psel, penable, pwrite, paddr, pwdata : master -> slave
//   prdata, pready, pslverr              : slave  -> master
// Clock and reset are kept outside the bundle as plain ports.
// ---------------------------------------------------------------------------
interface apb_gpio_slave_if;
  import apb_gpio_pkg::*;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [APB_ADDR_W-1:0] paddr;
  logic [APB_DATA_W-1:0] pwdata;
  logic [APB_DATA_W-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_gpio_slave_gpio_in_sync.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// gpio_in_sync
// Two-flop synchroniser for the asynchronous GPIO pads, followed by a
// one-cycle history stage so rising edges can be detected in the clock
// domain.
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset
//   asyncIn_i  : raw pad inputs
//   sync_o     : synchronised inputs (two flops after the pad)
//   rise_o     : high for one cycle when a synchronised bit goes 0 -> 1
// ---------------------------------------------------------------------------
module gpio_in_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] asyncIn_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= asyncIn_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/apb_gpio_slave.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// apb_gpio_slave
// APB3 slave exposing an IO_NUM-bit GPIO port with per-bit direction,
// synchronised inputs and per-bit edge/level interrupts.
//   clk_i      : sole clock (PCLK)
//   rst_ni     : asynchronous active-low reset (PRESETN)
//   apb        : APB3 slave modport (PSEL/PENABLE/PWRITE/PADDR/PWDATA in,
//                PRDATA/PREADY/PSLVERR out)
//   gpioIn_i   : asynchronous pad inputs
//   gpioOut_o  : output data (DATA_OUT register)
//   gpioOe_o   : output enable, 1 = drive (DIR register)
//   int_o      : OR of the interrupt status bits
// Register map (byte offsets): 0x00 DATA_OUT, 0x04 DATA_IN (RO), 0x08 DIR,
// 0x0C INT_EN, 0x10 INT_EDGE (1 = rising edge, 0 = level high),
// 0x14 INT_STAT (write 1 to clear).
// ---------------------------------------------------------------------------
module apb_gpio_slave
  import apb_gpio_pkg::*;
#(
  parameter int IO_NUM      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  apb_gpio_slave_if.slave   apb,
  input  logic [IO_NUM-1:0] gpioIn_i,
  output logic [IO_NUM-1:0] gpioOut_o,
  output logic [IO_NUM-1:0] gpioOe_o,
  output logic              int_o
);

  // Out-of-range settings are clamped rather than wrapping the counter
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES > MAX_WAIT) ? CNT_W'(MAX_WAIT) : CNT_W'(WAIT_STATES);

  apb_state_e       state_q, state_d;
  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;

  logic [IO_NUM-1:0] dataOut_q, dataOut_d;
  logic [IO_NUM-1:0] dir_q, dir_d;
  logic [IO_NUM-1:0] intEn_q, intEn_d;
  logic [IO_NUM-1:0] intEdge_q, intEdge_d;
  logic [IO_NUM-1:0] intStat_q, intStat_d;

  logic [IO_NUM-1:0] syncIn;
  logic [IO_NUM-1:0] riseIn;
  logic [IO_NUM-1:0] intEvent;
  logic [IO_NUM-1:0] w1cMask;
  logic [IO_NUM-1:0] wrData;

  logic [5:0]            regIdx;
  logic                  accessErr;
  logic                  readyInt;
  logic                  wrCommit;
  logic [APB_DATA_W-1:0] readData;
  logic                  unusedBits;

  gpio_in_sync #(
    .WIDTH (IO_NUM)
  ) u_sync (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .asyncIn_i (gpioIn_i),
    .sync_o    (syncIn),
    .rise_o    (riseIn)
  );

  assign regIdx     = apb.paddr[7:2];
  assign wrData     = apb.pwdata[IO_NUM-1:0];
  assign unusedBits = ^{apb.paddr[1:0], apb.pwdata};

  // Unmapped offsets and writes to the read-only input register are errored
  assign accessErr = (regIdx > IDX_INT_STAT) ||
                     (apb.pwrite && (regIdx == IDX_DATA_IN));

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // FSM next state. IDLE observes the setup phase; SETUP is the first
  // access-phase cycle after the counter load and ACCESS covers any further
  // wait cycles. A completed transfer returns to IDLE, which picks up a
  // back-to-back setup phase on the following cycle. A setup phase seen
  // mid-transfer restarts the counter.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    case (state_q)
      ST_IDLE: begin
        if (apb.psel && !apb.penable) begin
          state_d   = ST_SETUP;
          waitCnt_d = WAIT_LOAD;
        end
      end
      ST_SETUP, ST_ACCESS: begin
        if (!apb.psel) begin
          state_d = ST_IDLE;
        end else if (!apb.penable) begin
          state_d   = ST_SETUP;
          waitCnt_d = WAIT_LOAD;
        end else if (waitCnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_ACCESS;
          waitCnt_d = waitCnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: everything on the response side is zero except in the
  // single completing cycle.
  always_comb begin
    readyInt    = (state_q != ST_IDLE) && apb.psel && apb.penable &&
                  (waitCnt_q == '0);
    wrCommit    = readyInt && apb.pwrite && !accessErr;
    apb.pready  = readyInt;
    apb.pslverr = readyInt && accessErr;
    apb.prdata  = (readyInt && !apb.pwrite && !accessErr) ? readData : '0;
  end

  always_comb begin
    readData = '0;
    case (regIdx)
      IDX_DATA_OUT: readData = APB_DATA_W'(dataOut_q);
      IDX_DATA_IN:  readData = APB_DATA_W'(syncIn);
      IDX_DIR:      readData = APB_DATA_W'(dir_q);
      IDX_INT_EN:   readData = APB_DATA_W'(intEn_q);
      IDX_INT_EDGE: readData = APB_DATA_W'(intEdge_q);
      IDX_INT_STAT: readData = APB_DATA_W'(intStat_q);
      default:      readData = '0;
    endcase
  end

  assign intEvent = intEn_q & ((intEdge_q & riseIn) | (~intEdge_q & syncIn));

  // Register next state. In INT_STAT a new event wins over a clear of the
  // same bit in the same cycle, so an edge is never lost.
  always_comb begin
    dataOut_d = dataOut_q;
    dir_d     = dir_q;
    intEn_d   = intEn_q;
    intEdge_d = intEdge_q;
    w1cMask   = '0;
    if (wrCommit) begin
      case (regIdx)
        IDX_DATA_OUT: dataOut_d = wrData;
        IDX_DIR:      dir_d     = wrData;
        IDX_INT_EN:   intEn_d   = wrData;
        IDX_INT_EDGE: intEdge_d = wrData;
        IDX_INT_STAT: w1cMask   = wrData;
        default:      w1cMask   = '0;
      endcase
    end
    intStat_d = (intStat_q & ~w1cMask) | intEvent;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dataOut_q <= '0;
      dir_q     <= '0;
      intEn_q   <= '0;
      intEdge_q <= '0;
      intStat_q <= '0;
    end else begin
      dataOut_q <= dataOut_d;
      dir_q     <= dir_d;
      intEn_q   <= intEn_d;
      intEdge_q <= intEdge_d;
      intStat_q <= intStat_d;
    end
  end

  assign gpioOut_o = dataOut_q;
  assign gpioOe_o  = dir_q;
  assign int_o     = |intStat_q;

endmodule

// File: tb/tb_apb_gpio_slave.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_apb_gpio_slave
// Self-checking bench for apb_gpio_slave built with two wait states.
// ---------------------------------------------------------------------------
module tb_apb_gpio_slave;

  localparam int IO_NUM = 8;
  localparam int WS     = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [IO_NUM-1:0] gpioIn = '0;
  logic [IO_NUM-1:0] gpioOut;
  logic [IO_NUM-1:0] gpioOe;
  logic              intOut;

  int checks = 0;
  int passes = 0;

  // Expected read responses {pslverr, prdata}
  logic [32:0] expQ[$];

  apb_gpio_slave_if apb ();

  apb_gpio_slave #(
    .IO_NUM      (IO_NUM),
    .WAIT_STATES (WS)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .apb       (apb),
    .gpioIn_i  (gpioIn),
    .gpioOut_o (gpioOut),
    .gpioOe_o  (gpioOe),
    .int_o     (intOut)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Runs one APB transfer starting just after a rising edge; returns the
  // response and the number of access cycles with PREADY low. On timeout
  // the response is forced to values no test expects.
  task automatic apbXfer(input logic wr, input logic [7:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int waits);
    bit done;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = wr;
    apb.paddr   = addr;
    apb.pwdata  = wdata;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    waits = 0;
    done  = 1'b0;
    rdata = '1;
    err   = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (apb.pready === 1'b1) begin
        rdata = apb.prdata;
        err   = apb.pslverr;
        done  = 1'b1;
      end else begin
        waits++;
      end
    end
    @(posedge clk); #1;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic err;
    int w;
    logic [32:0] exp;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({gpioOut, gpioOe, intOut, apb.pready, apb.pslverr, apb.prdata} !== '0)
      $display("[TB] FAIL reset_outputs: got out=%h oe=%h int=%b rdy=%b err=%b rdata=%h, expected all 0",
               gpioOut, gpioOe, intOut, apb.pready, apb.pslverr, apb.prdata);
    else passes++;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      expQ.push_back({1'b0, 32'h0});
      apbXfer(1'b0, 8'(i * 4), 32'h0, rd, err, w);
      exp = expQ.pop_front();
      checks++;
      if ({err, rd} !== exp || w != WS)
        $display("[TB] FAIL reset_read_%0h: got err=%b data=%h waits=%0d, expected err=%b data=%h waits=%0d",
                 i * 4, err, rd, w, exp[32], exp[31:0], WS);
      else passes++;
    end
  endtask

  task automatic test_data_out();
    logic [31:0] rd;
    logic err;
    int w;
    logic [32:0] exp;
    apbXfer(1'b1, 8'h00, 32'h0000_00A5, rd, err, w);
    checks++;
    if (w != WS || err !== 1'b0)
      $display("[TB] FAIL dout_write_wait: got waits=%0d err=%b, expected waits=%0d err=0", w, err, WS);
    else passes++;
    checks++;
    if (gpioOut !== 8'hA5) $display("[TB] FAIL gpio_out: got %h, expected a5", gpioOut);
    else passes++;
    expQ.push_back({1'b0, 32'h0000_00A5});
    apbXfer(1'b0, 8'h00, 32'h0, rd, err, w);
    exp = expQ.pop_front();
    checks++;
    if ({err, rd} !== exp) $display("[TB] FAIL dout_readback: got %h, expected %h", {err, rd}, exp);
    else passes++;
    apbXfer(1'b1, 8'h08, 32'hFFFF_FF3C, rd, err, w);
    checks++;
    if (gpioOe !== 8'h3C) $display("[TB] FAIL gpio_oe: got %h, expected 3c", gpioOe);
    else passes++;
    expQ.push_back({1'b0, 32'h0000_003C});
    apbXfer(1'b0, 8'h08, 32'h0, rd, err, w);
    exp = expQ.pop_front();
    checks++;
    if ({err, rd} !== exp) $display("[TB] FAIL dir_upper_ignored: got %h, expected %h", {err, rd}, exp);
    else passes++;
  endtask

  task automatic test_data_in();
    logic [31:0] rd;
    logic err;
    int w;
    logic [32:0] exp;
    // Change lands two edges before the completing cycle: new value visible
    expQ.push_back({1'b0, 32'h0000_003C});
    fork
      apbXfer(1'b0, 8'h04, 32'h0, rd, err, w);
      begin @(posedge clk); #2 gpioIn = 8'h3C; end
    join
    exp = expQ.pop_front();
    checks++;
    if ({err, rd} !== exp) $display("[TB] FAIL din_two_cycles: got %h, expected %h", {err, rd}, exp);
    else passes++;
    // Change lands only one edge before the completing cycle: old value
    expQ.push_back({1'b0, 32'h0000_003C});
    fork
      apbXfer(1'b0, 8'h04, 32'h0, rd, err, w);
      begin @(posedge clk); @(posedge clk); #2 gpioIn = 8'h81; end
    join
    exp = expQ.pop_front();
    checks++;
    if ({err, rd} !== exp) $display("[TB] FAIL din_too_early: got %h, expected %h", {err, rd}, exp);
    else passes++;
    expQ.push_back({1'b0, 32'h0000_0081});
    apbXfer(1'b0, 8'h04, 32'h0, rd, err, w);
    exp = expQ.pop_front();
    checks++;
    if ({err, rd} !== exp) $display("[TB] FAIL din_settled: got %h, expected %h", {err, rd}, exp);
    else passes++;
    gpioIn = 8'h00;
    idle(4);
  endtask

  task automatic test_edge_irq();
    logic [31:0] rd;
    logic err;
    int w;
    logic [32:0] exp;
    apbXfer(1'b1, 8'h10, 32'h01, rd, err, w);
    apbXfer(1'b1, 8'h0C, 32'h01, rd, err, w);
    gpioIn = 8'h01;
    repeat (3) @(negedge clk);
    checks++;
    if (intOut !== 1'b0) $display("[TB] FAIL irq_latency_early: got %b, expected 0", intOut);
    else passes++;
    @(negedge clk);
    checks++;
    if (intOut !== 1'b1) $display("[TB] FAIL irq_latency: got %b, expected 1", intOut);
    else passes++;
    @(posedge clk); #1;
    expQ.push_back({1'b0, 32'h0000_0001});
    apbXfer(1'b0, 8'h14, 32'h0, rd, err, w);
    exp = expQ.pop_front();
    checks++;
    if ({err, rd} !== exp) $display("[TB] FAIL int_stat_edge: got %h, expected %h", {err, rd}, exp);
    else passes++;
    apbXfer(1'b1, 8'h14, 32'h01, rd, err, w);
    checks++;
    if (intOut !== 1'b0) $display("[TB] FAIL irq_w1c: got %b, expected 0", intOut);
    else passes++;
    // New edge arrives in the same cycle as the clear: the bit must survive
    gpioIn = 8'h00;
    idle(3);
    fork
      apbXfer(1'b1, 8'h14, 32'h01, rd, err, w);
      begin @(posedge clk); #2 gpioIn = 8'h01; end
    join
    checks++;
    if (intOut !== 1'b1) $display("[TB] FAIL irq_set_wins: got %b, expected 1", intOut);
    else passes++;
    apbXfer(1'b1, 8'h0C, 32'h00, rd, err, w);
    expQ.push_back({1'b0, 32'h0000_0001});
    apbXfer(1'b0, 8'h14, 32'h0, rd, err, w);
    exp = expQ.pop_front();
    checks++;
    if ({err, rd} !== exp || intOut !== 1'b1)
      $display("[TB] FAIL int_en_keeps_stat: got %h int=%b, expected %h int=1", {err, rd}, intOut, exp);
    else passes++;
    apbXfer(1'b1, 8'h14, 32'h01, rd, err, w);
    checks++;
    if (intOut !== 1'b0) $display("[TB] FAIL irq_final_clear: got %b, expected 0", intOut);
    else passes++;
  endtask

  task automatic test_level_irq();
    logic [31:0] rd;
    logic err;
    int w;
    logic [32:0] exp;
    apbXfer(1'b1, 8'h10, 32'h00, rd, err, w);
    gpioIn = 8'h03;
    apbXfer(1'b1, 8'h0C, 32'h02, rd, err, w);
    idle(3);
    expQ.push_back({1'b0, 32'h0000_0002});
    apbXfer(1'b0, 8'h14, 32'h0, rd, err, w);
    exp = expQ.pop_front();
    checks++;
    if ({err, rd} !== exp) $display("[TB] FAIL level_stat: got %h, expected %h", {err, rd}, exp);
    else passes++;
    apbXfer(1'b1, 8'h14, 32'h02, rd, err, w);
    idle(2);
    expQ.push_back({1'b0, 32'h0000_0002});
    apbXfer(1'b0, 8'h14, 32'h0, rd, err, w);
    exp = expQ.pop_front();
    checks++;
    if ({err, rd} !== exp || intOut !== 1'b1)
      $display("[TB] FAIL level_reassert: got %h int=%b, expected %h int=1", {err, rd}, intOut, exp);
    else passes++;
    gpioIn = 8'h00;
    idle(4);
    apbXfer(1'b1, 8'h14, 32'h02, rd, err, w);
    idle(2);
    checks++;
    if (intOut !== 1'b0) $display("[TB] FAIL level_cleared: got %b, expected 0", intOut);
    else passes++;
    apbXfer(1'b1, 8'h0C, 32'h00, rd, err, w);
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic err;
    int w;
    logic [32:0] exp;
    gpioIn = 8'h5A;
    idle(3);
    apbXfer(1'b1, 8'h04, 32'hFF, rd, err, w);
    checks++;
    if (err !== 1'b1 || w != WS)
      $display("[TB] FAIL err_write_datain: got err=%b waits=%0d, expected err=1 waits=%0d", err, w, WS);
    else passes++;
    expQ.push_back({1'b0, 32'h0000_005A});
    apbXfer(1'b0, 8'h04, 32'h0, rd, err, w);
    exp = expQ.pop_front();
    checks++;
    if ({err, rd} !== exp) $display("[TB] FAIL datain_unchanged: got %h, expected %h", {err, rd}, exp);
    else passes++;
    expQ.push_back({1'b1, 32'h0});
    apbXfer(1'b0, 8'h20, 32'h0, rd, err, w);
    exp = expQ.pop_front();
    checks++;
    if ({err, rd} !== exp) $display("[TB] FAIL err_read_unmapped: got %h, expected %h", {err, rd}, exp);
    else passes++;
    apbXfer(1'b1, 8'h18, 32'h12, rd, err, w);
    checks++;
    if (err !== 1'b1) $display("[TB] FAIL err_write_unmapped: got %b, expected 1", err);
    else passes++;
    // Byte-lane bits ignored: 0x03 decodes as DATA_OUT, untouched by 0x18
    expQ.push_back({1'b0, 32'h0000_00A5});
    apbXfer(1'b0, 8'h03, 32'h0, rd, err, w);
    exp = expQ.pop_front();
    checks++;
    if ({err, rd} !== exp) $display("[TB] FAIL dout_after_errors: got %h, expected %h", {err, rd}, exp);
    else passes++;
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    logic err;
    int w;
    logic [32:0] exp;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b1;
    apb.paddr   = 8'h00;
    apb.pwdata  = 32'h5A;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    @(negedge clk);
    checks++;
    if (apb.pready !== 1'b0) $display("[TB] FAIL abort_ready: got %b, expected 0", apb.pready);
    else passes++;
    @(posedge clk); #1;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    idle(3);
    checks++;
    if (gpioOut !== 8'hA5) $display("[TB] FAIL abort_no_commit: got %h, expected a5", gpioOut);
    else passes++;
    expQ.push_back({1'b0, 32'h0000_00A5});
    apbXfer(1'b0, 8'h00, 32'h0, rd, err, w);
    exp = expQ.pop_front();
    checks++;
    if ({err, rd} !== exp) $display("[TB] FAIL abort_readback: got %h, expected %h", {err, rd}, exp);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic err;
    int w;
    logic [32:0] exp;
    logic [7:0]  addrs[3] = '{8'h00, 8'h08, 8'h10};
    logic [31:0] vals[3]  = '{32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 3; i++) apbXfer(1'b1, addrs[i], vals[i], rd, err, w);
    for (int i = 0; i < 3; i++) begin
      expQ.push_back({1'b0, vals[i]});
      apbXfer(1'b0, addrs[i], 32'h0, rd, err, w);
      exp = expQ.pop_front();
      checks++;
      if ({err, rd} !== exp || w != WS)
        $display("[TB] FAIL b2b_read_%0h: got %h waits=%0d, expected %h waits=%0d",
                 addrs[i], {err, rd}, w, exp, WS);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic err;
    int w;
    logic [32:0] exp;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b1;
    apb.paddr   = 8'h00;
    apb.pwdata  = 32'h77;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (gpioOut !== 8'h00 || gpioOe !== 8'h00 || apb.pready !== 1'b0)
      $display("[TB] FAIL reset_mid: got out=%h oe=%h rdy=%b, expected 00 00 0", gpioOut, gpioOe, apb.pready);
    else passes++;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    expQ.push_back({1'b0, 32'h0});
    apbXfer(1'b0, 8'h00, 32'h0, rd, err, w);
    exp = expQ.pop_front();
    checks++;
    if ({err, rd} !== exp) $display("[TB] FAIL reset_mid_readback: got %h, expected %h", {err, rd}, exp);
    else passes++;
  endtask

  initial begin
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    apb.paddr   = '0;
    apb.pwdata  = '0;
    test_reset();
    test_data_out();
    test_data_in();
    test_edge_irq();
    test_level_irq();
    test_errors();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/apb_gpio_slave.md
# apb_gpio_slave

APB3 slave providing an 8-bit general-purpose I/O port with per-bit direction, synchronised inputs and edge/level interrupts. Sits directly downstream of the AHB-Lite-to-APB bridge in the bus-functional-model test environment, consuming one PSEL line and driving PRDATA/PREADY/PSLVERR back to the bridge. Used as the register-level target that BFM scripts exercise, and as a model of a GPIO peripheral on the APB fabric.

## Interface
- IO_NUM, 8, number of GPIO bits (1..32)
- WAIT_STATES, 0, PREADY-low cycles inserted per access (0..3)
- PCLK  in  1  sole clock
- PRESETN  in  1  asynchronous active-low reset
- PSEL  in  1  slave select (one bit of bridge PSEL vector)
- PENABLE  in  1  APB access phase
- PWRITE  in  1  1 = write
- PADDR  in  8  byte address, bits [1:0] ignored
- PWDATA  in  32  write data
- PRDATA  out  32  read data, zero-extended above IO_NUM
- PREADY  out  1  transfer complete
- PSLVERR  out  1  error, valid with PREADY
- GPIO_IN  in  IO_NUM  asynchronous pad inputs
- GPIO_OUT  out  IO_NUM  output data
- GPIO_OE  out  IO_NUM  output enable, 1 = drive
- INT  out  1  OR of INT_STAT

## Operation
- Registers (offset, access, reset 0): 0x00 DATA_OUT RW; 0x04 DATA_IN RO; 0x08 DIR RW; 0x0C INT_EN RW; 0x10 INT_EDGE RW (1 = rising edge, 0 = level-high); 0x14 INT_STAT RW1C.
- GPIO_OUT = DATA_OUT, GPIO_OE = DIR, straight from registers.
- DATA_IN reads the 2-flop synchronised GPIO_IN.
- Interrupt event per bit i: INT_EDGE[i] ? (sync[i] & ~prev[i]) : sync[i]; gated by INT_EN[i]; sets INT_STAT[i].
- W1C on INT_STAT: set wins over clear in the same cycle; level source still high re-sets the bit the next cycle.
- Clearing INT_EN does not clear INT_STAT.
- PSLVERR = 1 for an unmapped offset (>0x14) and for a write to DATA_IN; the write is dropped, reads return 0.
- FSM: IDLE -> SETUP on PSEL & ~PENABLE (load wait counter = WAIT_STATES) -> ACCESS; in ACCESS, counter decrements while non-zero with PREADY = 0; PREADY = 1 when counter = 0, then back to IDLE (or SETUP on back-to-back PSEL).
- Write commits, and read data is presented, only in the cycle PSEL & PENABLE & PREADY.
- PSEL falling in ACCESS before PREADY: abort to IDLE, no commit.

## Timing
- Reset values: PRDATA = 0, PREADY = 0, PSLVERR = 0, GPIO_OUT = 0, GPIO_OE = 0, INT = 0; FSM in IDLE; sync flops 0.
- PREADY, PSLVERR, PRDATA are 0 outside the completing access cycle.
- Access length: 2 + WAIT_STATES PCLK cycles (setup + access).
- GPIO_OUT/GPIO_OE change on the PCLK edge that ends the write access phase.
- GPIO_IN to DATA_IN: 2 cycles; to INT_STAT set: 3 cycles; INT follows INT_STAT combinationally.
- Reset asserted mid-transfer: all state to reset values immediately, no partial write.
- Bits above IO_NUM: writes ignored, reads 0.

## Structure
- Package apb_gpio_pkg: register offset constants, FSM state enum, MAX_WAIT = 3.
- Sub-module gpio_in_sync: 2-flop synchroniser plus prev stage, outputs sync and rise vectors.

## Test plan
- Reset, then read all six offsets -> every PRDATA = 0x0, PSLVERR = 0.
- WAIT_STATES = 2: write DATA_OUT = 0xA5 -> PREADY low 2 cycles, then high; GPIO_OUT = 0xA5 next edge; readback 0xA5.
- GPIO_IN = 0x3C -> DATA_IN reads 0x3C from cycle 2 after change; before that reads old value.
- INT_EN = 0x01, INT_EDGE = 0x01, GPIO_IN[0] 0->1 -> INT_STAT = 0x01, INT = 1 on cycle 3; write INT_STAT = 0x01 -> INT = 0; edge and W1C in same cycle -> bit stays 1.
- INT_EDGE = 0, GPIO_IN[1] held high, INT_EN = 0x02: W1C 0x02 -> INT_STAT re-sets next cycle.
- Write to 0x04 and read 0x20 -> PSLVERR = 1, DATA_IN unchanged, PRDATA = 0; PSEL dropped mid-wait -> no commit.
